// File: rtl/instr_encoder_loader.sv
// Streams instruction descriptors into instruction memory as encoded RV32I words.
// A one-entry output register holds the pending write, so a new descriptor is taken when it drains.
module instr_encoder_loader #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_count;

  logic              w_wr_done;
  logic              w_in_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_ptr_now;
  logic [ADDR_W-1:0] w_base_aligned;
  logic              w_i_ok;
  logic              w_b_ok;
  logic              w_j_ok;
  logic [31:0]       w_word;
  logic              w_enc_err;

  assign w_wr_done      = r_mem_we && mem_ready;
  assign w_in_ready     = (r_state == S_RUN) && (!r_mem_we || mem_ready);
  assign w_accept       = in_valid && w_in_ready;
  assign w_base_aligned = base_addr & ~(ADDR_W'(3));
  // A write retiring this cycle frees the slot at r_ptr, so the new word lands one word further.
  assign w_ptr_now      = w_wr_done ? r_ptr + ADDR_W'(4) : r_ptr;

  // Immediate fits its field when all bits above the field agree with the field's sign bit.
  assign w_i_ok = (&imm[31:11]) | ~(|imm[31:11]);
  assign w_b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign w_j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    w_word    = 32'h0000_0013;
    w_enc_err = 1'b0;
    case (op)
      4'd0:  w_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd1:  w_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      4'd2:  w_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      4'd3:  w_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      4'd4:  w_word = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
      4'd5: begin
        w_word    = {imm[11:0], rs1, 3'b000, rd, 7'b0010011};
        w_enc_err = ~w_i_ok;
      end
      4'd6: begin
        w_word    = {imm[11:0], rs1, 3'b111, rd, 7'b0010011};
        w_enc_err = ~w_i_ok;
      end
      4'd7: begin
        w_word    = {imm[11:0], rs1, 3'b110, rd, 7'b0010011};
        w_enc_err = ~w_i_ok;
      end
      4'd8: begin
        w_word    = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
        w_enc_err = ~w_i_ok;
      end
      4'd9: begin
        w_word    = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
        w_enc_err = ~w_i_ok;
      end
      4'd10: begin
        w_word    = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
        w_enc_err = ~w_b_ok;
      end
      4'd11: begin
        w_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        w_enc_err = ~w_j_ok;
      end
      4'd12: begin
        w_word    = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
        w_enc_err = ~w_i_ok;
      end
      4'd13: begin
        w_word    = {imm[31:12], rd, 7'b0110111};
        w_enc_err = |imm[11:0];
      end
      default: begin
        w_word    = 32'h0000_0013;
        w_enc_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_done) begin
        r_ptr   <= r_ptr + ADDR_W'(4);
        r_count <= r_count + 16'd1;
      end
      if (w_accept) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= w_ptr_now;
        r_mem_wdata <= w_word;
        if (w_enc_err) r_err <= 1'b1;
      end else if (w_wr_done) begin
        r_mem_we <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_ptr   <= w_base_aligned;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept && in_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_wr_done) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench: driver pushes reference-model words at acceptance, a monitor pops them
// at every completed memory write; directed sessions cover the worked examples, then random ones.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [3:0]  op = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [31:0] imm = '0;
  logic        mem_we;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] count;

  instr_encoder_loader #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  int          wr_cyc[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          exp_count = 0;
  int          stall_cnt = 0;
  int          stall_seen = 0;
  logic [31:0] exp_ptr = '0;
  bit          exp_err = 1'b0;
  bit          mon_en = 1'b1;
  bit          mem_rand = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_data = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder: fields placed by arithmetic, ranges checked on the signed value.
  function automatic logic [32:0] ref_encode(input logic [3:0] o, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input logic [31:0] u);
    int          v;
    logic [31:0] w, fd, f1, f2;
    bit          e;
    v  = int'(u);
    fd = 32'(d) << 7;
    f1 = 32'(s1) << 15;
    f2 = 32'(s2) << 20;
    e  = 1'b0;
    w  = 32'h13;
    case (o)
      4'd0: w = f2 | f1 | fd | 32'h33;
      4'd1: w = (32'h20 << 25) | f2 | f1 | fd | 32'h33;
      4'd2: w = f2 | f1 | (32'd7 << 12) | fd | 32'h33;
      4'd3: w = f2 | f1 | (32'd6 << 12) | fd | 32'h33;
      4'd4: w = f2 | f1 | (32'd2 << 12) | fd | 32'h33;
      4'd5, 4'd6, 4'd7, 4'd8, 4'd12: begin
        logic [31:0] f3, opc;
        f3  = (o == 4'd6) ? 32'd7 : (o == 4'd7) ? 32'd6 : (o == 4'd8) ? 32'd2 : 32'd0;
        opc = (o == 4'd8) ? 32'h03 : (o == 4'd12) ? 32'h67 : 32'h13;
        w = ((u & 32'hFFF) << 20) | f1 | (f3 << 12) | fd | opc;
        e = (v < -2048) || (v > 2047);
      end
      4'd9: begin
        w = (((u >> 5) & 32'h7F) << 25) | f2 | f1 | (32'd2 << 12) | ((u & 32'h1F) << 7) | 32'h23;
        e = (v < -2048) || (v > 2047);
      end
      4'd10: begin
        w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | f2 | f1 |
            (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
        e = (v < -4096) || (v > 4094) || ((u & 32'h1) != 0);
      end
      4'd11: begin
        w = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
            (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | fd | 32'h6F;
        e = (v < -1048576) || (v > 1048574) || ((u & 32'h1) != 0);
      end
      4'd13: begin
        w = (u & 32'hFFFFF000) | fd | 32'h37;
        e = (u & 32'hFFF) != 0;
      end
      default: begin
        w = 32'h13;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic logic [31:0] rand_imm(input logic [3:0] o);
    int r;
    r = int'($urandom_range(0, 9));
    if (r >= 7) return $urandom;
    case (o)
      4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12: return 32'(int'($urandom_range(0, 4095)) - 2048);
      4'd10: return 32'(int'($urandom_range(0, 4095)) * 2 - 4096);
      4'd11: return 32'(int'($urandom_range(0, 1048575)) * 2 - 1048576);
      4'd13: return $urandom & 32'hFFFFF000;
      default: return $urandom;
    endcase
  endfunction

  // Memory side: scheduled stalls first, otherwise random or always-ready.
  initial forever begin
    @(negedge clk);
    #1;
    if (stall_cnt > 0) begin
      mem_ready = 1'b0;
      stall_cnt--;
    end else begin
      mem_ready = mem_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: samples just before the rising edge that acts on these values.
  initial forever begin
    wr_t e;
    @(negedge clk);
    #2;
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (!busy) chk("in_ready_idle", 32'(in_ready), 32'd0);
      if (prev_stall) begin
        chk("hold_we", 32'(mem_we), 32'd1);
        chk("hold_addr", mem_addr, prev_addr);
        chk("hold_data", mem_wdata, prev_data);
      end
      if (mem_we && !mem_ready) begin
        chk("in_ready_stall", 32'(in_ready), 32'd0);
        stall_seen++;
      end
      if (mem_we && mem_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          $display("write addr=0x%08h data=0x%08h expect 0x%08h@0x%08h",
                   mem_addr, mem_wdata, e.data, e.addr);
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
        exp_count++;
        wr_cyc.push_back(cyc);
      end
      if (done) begin
        chk("done_count", 32'(count), 32'(exp_count[15:0]));
        chk("done_err", 32'(err), 32'(exp_err));
        chk("done_busy", 32'(busy), 32'd0);
      end
      prev_stall = mem_we && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  task automatic do_start(input logic [31:0] b);
    @(negedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    exp_ptr   = b & ~32'd3;
    exp_count = 0;
    exp_err   = 1'b0;
    sb_q.delete();
    wr_cyc.delete();
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("start_err", 32'(err), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(count), 32'd0);
  endtask

  task automatic ignored_start();
    @(negedge clk);
    #1;
    in_valid  = 1'b0;
    start     = 1'b1;
    base_addr = $urandom;
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input bit last,
                      input bit use_exp, input logic [31:0] exp_w);
    logic [32:0] r;
    int          budget;
    bit          acc;
    wr_t         e;
    budget = 0;
    acc    = 1'b0;
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last;
    #1;
    while (!acc && budget <= 200) begin
      if (in_ready) acc = 1'b1;
      else begin
        budget++;
        @(negedge clk);
        #2;
      end
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no acceptance for op %0d, required acceptance", o);
      in_valid = 1'b0;
    end else begin
      r      = ref_encode(o, d, s1, s2, im);
      e.addr = exp_ptr;
      e.data = use_exp ? exp_w : r[31:0];
      sb_q.push_back(e);
      exp_ptr = exp_ptr + 32'd4;
      if (r[32]) exp_err = 1'b1;
      acc_cyc = cyc;
    end
  endtask

  task automatic wait_done(input bit garbage);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      #1;
      if (garbage) begin
        in_valid = 1'b1;
        in_last  = 1'($urandom);
        op       = 4'($urandom);
        imm      = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      if (done) seen = 1'b1;
      n++;
    end
    in_valid = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done pulse, required done");
    end
    chk("queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Back-to-back ADD/SUB at 0x100: one-cycle latency and one word per cycle.
    do_start(32'h100);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
    begin
      int a0;
      a0 = acc_cyc;
      send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 1'b1, 32'h402081B3);
      wait_done(1'b0);
      chk("s1_writes", 32'(wr_cyc.size()), 32'd2);
      if (wr_cyc.size() == 2) begin
        chk("s1_latency", 32'(wr_cyc[0] - a0), 32'd1);
        chk("s1_throughput", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
      end
    end

    // Reference encodings; low base bits must be ignored.
    do_start(32'h1003);
    send(4'd5,  5'd5, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFF00293);
    send(4'd8,  5'd6, 5'd2, 5'd0, 32'd8,        1'b0, 1'b1, 32'h00812303);
    send(4'd9,  5'd0, 5'd2, 5'd6, 32'd8,        1'b0, 1'b1, 32'h00612423);
    send(4'd10, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b0, 1'b1, 32'hFE208EE3);
    send(4'd11, 5'd1, 5'd0, 5'd0, 32'd8,        1'b0, 1'b1, 32'h008000EF);
    send(4'd13, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b1, 1'b1, 32'h123450B7);
    wait_done(1'b0);

    // Three-cycle memory stall on the first word.
    do_start(32'h2000);
    stall_seen = 0;
    send(4'd5, 5'd1, 5'd2, 5'd0, 32'd5, 1'b0, 1'b0, 32'd0);
    stall_cnt = 3;
    send(4'd7, 5'd2, 5'd3, 5'd0, 32'h7F, 1'b1, 1'b0, 32'd0);
    wait_done(1'b0);
    chk("stall_cycles", 32'(stall_seen), 32'd3);

    // Encoding errors are sticky and still write; the next start clears them.
    do_start(32'h3000);
    send(4'd5, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1'b1, 32'h80000093);
    send(4'd15, 5'd7, 5'd7, 5'd7, 32'd1, 1'b1, 1'b1, 32'h00000013);
    wait_done(1'b0);
    chk("err_sticky", 32'(err), 32'd1);
    do_start(32'h4000);
    send(4'd0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 1'b0, 32'd0);
    wait_done(1'b0);

    // Reset during a stalled write abandons it.
    mon_en = 1'b0;
    do_start(32'h500);
    stall_cnt = 1000;
    send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    stall_cnt = 0;
    chk("post_rst_we", 32'(mem_we), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("idle_no_write", 32'(mem_we), 32'd0);
      in_valid = 1'b1;
      #1;
      chk("idle_no_accept", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    sb_q.delete();
    mon_en = 1'b1;

    // Random sessions with random memory back-pressure.
    mem_rand = 1'b1;
    for (int s = 0; s < 10; s++) begin
      int n;
      n = int'($urandom_range(3, 16));
      do_start((s == 3) ? 32'hFFFFFFF6 : $urandom);
      for (int i = 0; i < n; i++) begin
        logic [3:0] o;
        o = 4'($urandom);
        if (i == n / 2 && $urandom_range(0, 1) == 1) ignored_start();
        else if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          #1;
          in_valid = 1'b0;
        end
        send(o, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(o), (i == n - 1),
             1'b0, 32'd0);
      end
      wait_done(1'b1);
    end
    mem_rand = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
